// File: rtl/seq_mac_driver.sv
// Job sequencer for the bit-serial K-wide MAC: pulls operand beats, chains each result back as C.
// Optional SEQ_MAC_DRIVER_PERF_EN adds perf_cycles_o / perf_stall_o job counters.
module seq_mac_driver #(
   parameter int K         = 2,
   parameter int MAX_WIDTH = 16,
   parameter int P         = 2,
   parameter int LEN_W     = 8,
   localparam int BS_W     = $clog2(MAX_WIDTH / P) + 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              job_valid_i,
   output logic                              job_ready_o,
   input  logic [LEN_W-1:0]                  job_len_i,
   input  logic [31:0]                       job_bias_i,
   input  logic [BS_W-1:0]                   job_bs_a_i,
   input  logic [BS_W-1:0]                   job_bs_b_i,
   input  logic                              op_valid_i,
   output logic                              op_ready_o,
   input  logic signed [K-1:0][MAX_WIDTH-1:0] op_row_i,
   input  logic signed [K-1:0][MAX_WIDTH-1:0] op_col_i,
   output logic                              mac_valid_o,
   input  logic                              mac_ready_i,
   output logic [K-1:0][MAX_WIDTH-1:0]       mac_row_o,
   output logic [K-1:0][MAX_WIDTH-1:0]       mac_col_o,
   output logic [31:0]                       mac_c_o,
   output logic [BS_W-1:0]                   mac_bs_a_o,
   output logic [BS_W-1:0]                   mac_bs_b_o,
   input  logic                              mac_valid_i,
   output logic                              mac_ready_o,
   input  logic [31:0]                       mac_d_i,
   output logic                              res_valid_o,
   input  logic                              res_ready_i,
   output logic [31:0]                       res_data_o,
`ifdef SEQ_MAC_DRIVER_PERF_EN
   output logic                              res_err_o,
   output logic [31:0]                       perf_cycles_o,
   output logic [31:0]                       perf_stall_o
`else
   output logic                              res_err_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   localparam logic [BS_W-1:0] BS_MAX = BS_W'(MAX_WIDTH / P);

   function automatic logic bs_legal(input logic [BS_W-1:0] bs);
      return (bs != {BS_W{1'b0}}) && (bs <= BS_MAX);
   endfunction

   state_t                       state_q, state_d;
   logic [31:0]                  acc_q, acc_d;
   logic [LEN_W-1:0]             rem_q, rem_d;
   logic [BS_W-1:0]              bs_a_q, bs_a_d, bs_b_q, bs_b_d;
   logic [K-1:0][MAX_WIDTH-1:0]  row_q, row_d, col_q, col_d;
   logic                         err_q, err_d;
   logic                         job_ready_q, op_ready_q, mac_valid_q, mac_ready_q, res_valid_q;
   logic                         job_legal_s;

   assign job_legal_s = bs_legal(job_bs_a_i) && bs_legal(job_bs_b_i);

   // Next-state and datapath updates; illegal jobs still drain their beats to keep the stream aligned
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      bs_a_d  = bs_a_q;
      bs_b_d  = bs_b_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (job_valid_i) begin
               acc_d  = job_bias_i;
               rem_d  = job_len_i;
               bs_a_d = job_bs_a_i;
               bs_b_d = job_bs_b_i;
               err_d  = !job_legal_s;
               if (job_len_i == {LEN_W{1'b0}}) begin
                  state_d = S_DONE;
               end else if (!job_legal_s) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (op_valid_i) begin
               row_d   = op_row_i;
               col_d   = op_col_i;
               state_d = S_ISSUE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_ISSUE: begin
            if (mac_ready_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (mac_valid_i) begin
               acc_d   = mac_d_i;
               rem_d   = rem_q - LEN_W'(1);
               state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_FETCH;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DRAIN: begin
            if (op_valid_i) begin
               rem_d   = rem_q - LEN_W'(1);
               state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_DRAIN;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and handshake outputs, all registered from the next state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         acc_q       <= 32'd0;
         rem_q       <= {LEN_W{1'b0}};
         bs_a_q      <= {BS_W{1'b0}};
         bs_b_q      <= {BS_W{1'b0}};
         row_q       <= '0;
         col_q       <= '0;
         err_q       <= 1'b0;
         job_ready_q <= 1'b1;
         op_ready_q  <= 1'b0;
         mac_valid_q <= 1'b0;
         mac_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         rem_q       <= rem_d;
         bs_a_q      <= bs_a_d;
         bs_b_q      <= bs_b_d;
         row_q       <= row_d;
         col_q       <= col_d;
         err_q       <= err_d;
         job_ready_q <= (state_d == S_IDLE);
         op_ready_q  <= (state_d == S_FETCH) || (state_d == S_DRAIN);
         mac_valid_q <= (state_d == S_ISSUE);
         mac_ready_q <= (state_d == S_WAIT);
         res_valid_q <= (state_d == S_DONE);
      end
   end

   assign job_ready_o = job_ready_q;
   assign op_ready_o  = op_ready_q;
   assign mac_valid_o = mac_valid_q;
   assign mac_ready_o = mac_ready_q;
   assign res_valid_o = res_valid_q;
   assign mac_row_o   = row_q;
   assign mac_col_o   = col_q;
   assign mac_c_o     = acc_q;
   assign mac_bs_a_o  = bs_a_q;
   assign mac_bs_b_o  = bs_b_q;
   assign res_data_o  = acc_q;
   assign res_err_o   = err_q;

`ifdef SEQ_MAC_DRIVER_PERF_EN
   logic [31:0] perf_cycles_q, perf_stall_q;

   // Job counters: restart on accept, run while a job is in flight, hold once back in IDLE
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_cycles_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else if (state_q == S_IDLE) begin
         if (job_valid_i) begin
            perf_cycles_q <= 32'd1;
            perf_stall_q  <= 32'd0;
         end else begin
            perf_cycles_q <= perf_cycles_q;
            perf_stall_q  <= perf_stall_q;
         end
      end else begin
         perf_cycles_q <= perf_cycles_q + 32'd1;
         if ((state_q == S_ISSUE) && !mac_ready_i) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end else begin
            perf_stall_q <= perf_stall_q;
         end
      end
   end

   assign perf_cycles_o = perf_cycles_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_seq_mac_driver.sv
// Bench for seq_mac_driver: job-level reference model, ideal MAC responder, random handshakes.
module tb_seq_mac_driver;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              job_valid_i, job_ready_o;
   logic [7:0]        job_len_i;
   logic [31:0]       job_bias_i;
   logic [4:0]        job_bs_a_i, job_bs_b_i;
   logic              op_valid_i, op_ready_o;
   logic [1:0][15:0]  op_row_i, op_col_i;
   logic              mac_valid_o, mac_ready_i;
   logic [1:0][15:0]  mac_row_o, mac_col_o;
   logic [31:0]       mac_c_o;
   logic [4:0]        mac_bs_a_o, mac_bs_b_o;
   logic              mac_valid_i, mac_ready_o;
   logic [31:0]       mac_d_i;
   logic              res_valid_o, res_ready_i;
   logic [31:0]       res_data_o;
   logic              res_err_o;
`ifdef SEQ_MAC_DRIVER_PERF_EN
   logic [31:0]       perf_cycles_o, perf_stall_o;
`endif

   seq_mac_driver dut (
      .clk_i(clk), .rst_i(rst_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_len_i(job_len_i),
      .job_bias_i(job_bias_i), .job_bs_a_i(job_bs_a_i), .job_bs_b_i(job_bs_b_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_row_i(op_row_i), .op_col_i(op_col_i),
      .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_row_o(mac_row_o),
      .mac_col_o(mac_col_o), .mac_c_o(mac_c_o), .mac_bs_a_o(mac_bs_a_o), .mac_bs_b_o(mac_bs_b_o),
      .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_d_i(mac_d_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
`ifdef SEQ_MAC_DRIVER_PERF_EN
      .res_err_o(res_err_o), .perf_cycles_o(perf_cycles_o), .perf_stall_o(perf_stall_o)
`else
      .res_err_o(res_err_o)
`endif
   );

   always #5 clk = ~clk;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // job description and reference model
   logic [1:0][15:0] rows [0:255];
   logic [1:0][15:0] cols [0:255];
   logic [31:0]      exp_c [0:256];
   logic [31:0]      exp_res;
   logic             exp_err;
   int               jb_len;
   logic [31:0]      jb_bias;
   logic [4:0]       jb_bsa, jb_bsb;
   logic             jb_legal;
   // progress tracking (phase 0: offering job, 1: in flight, 2: finished / none)
   int               phase = 2;
   int               beat_idx, issue_idx, since, op_lat, res_lat;
   int               stall_left, hold_left, mac_lat;
   bit               rnd;
   bit               mac_pend = 1'b0;
   logic [31:0]      pend_res;
   logic [31:0]      got_res;
   logic             got_err;
   logic [31:0]      c_seen [$];
   int               exp_cycles, exp_stall;
   bit               hs_job, hs_op, hs_mreq, hs_mres, hs_res;

   function automatic int dot(input logic [1:0][15:0] r, input logic [1:0][15:0] c);
      int s;
      int a;
      int b;
      s = 0;
      for (int k = 0; k < 2; k++) begin
         a = int'($signed(r[k]));
         b = int'($signed(c[k]));
         s = s + a * b;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One bench cycle at the falling edge: account for the last edge, compare, drive the next.
   task automatic step();
      @(negedge clk);
      if (hs_job) begin phase = 1; since = 0; end
      if (hs_op) beat_idx++;
      if (hs_mreq) begin mac_pend = 1'b1; mac_lat = rnd ? $urandom_range(0, 3) : 0; end
      if (hs_mres) begin mac_pend = 1'b0; issue_idx++; end
      if (hs_res) phase = 2;
      if (phase == 1) since++;

      check("job_ready", {31'd0, job_ready_o}, {31'd0, phase != 1});
      if (op_ready_o) begin
         check("op_ready_in_job", {31'd0, (phase == 1) && (beat_idx < jb_len)}, 32'd1);
         if (op_lat < 0) op_lat = since;
      end
      if (mac_ready_o) check("mac_ready_only_pending", {31'd0, mac_pend}, 32'd1);
      if (mac_valid_o || mac_pend) begin
         check("mac_in_legal_job", {31'd0, jb_legal && (issue_idx < jb_len) && (phase == 1)}, 32'd1);
         if (issue_idx < jb_len) begin
            check("mac_c", mac_c_o, exp_c[issue_idx]);
            check("mac_row", mac_row_o, rows[issue_idx]);
            check("mac_col", mac_col_o, cols[issue_idx]);
            check("mac_bs_a", {27'd0, mac_bs_a_o}, {27'd0, jb_bsa});
            check("mac_bs_b", {27'd0, mac_bs_b_o}, {27'd0, jb_bsb});
         end
      end
      if (res_valid_o) begin
         check("res_in_job", {31'd0, phase == 1}, 32'd1);
         check("res_data", res_data_o, exp_res);
         check("res_err", {31'd0, res_err_o}, {31'd0, exp_err});
         check("res_beats", beat_idx, jb_len);
         check("res_issues", issue_idx, jb_legal ? jb_len : 0);
         got_res = res_data_o;
         got_err = res_err_o;
         if (res_lat < 0) res_lat = since;
      end

      job_valid_i = (phase == 0);
      job_len_i   = 8'(jb_len);
      job_bias_i  = jb_bias;
      job_bs_a_i  = jb_bsa;
      job_bs_b_i  = jb_bsb;
      if ((phase == 1) && (beat_idx < jb_len)) begin
         if (!(op_valid_i && !hs_op)) op_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         op_row_i = rows[beat_idx];
         op_col_i = cols[beat_idx];
      end else begin
         op_valid_i = 1'b0;
      end
      if (mac_valid_o && (stall_left > 0)) begin
         mac_ready_i = 1'b0;
         stall_left--;
      end else begin
         mac_ready_i = rnd ? 1'($urandom_range(0, 1)) : mac_valid_o;
      end
      if (mac_pend) begin
         if (mac_lat > 0) begin
            mac_lat--;
            mac_valid_i = 1'b0;
         end else begin
            mac_valid_i = 1'b1;
            mac_d_i     = pend_res;
         end
      end else begin
         mac_valid_i = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
         mac_d_i     = 32'hDEADBEEF;
      end
      if (res_valid_o && (hold_left > 0)) begin
         res_ready_i = 1'b0;
         hold_left--;
      end else begin
         res_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      hs_job  = job_valid_i && job_ready_o;
      hs_op   = op_valid_i && op_ready_o;
      hs_mreq = mac_valid_o && mac_ready_i;
      hs_mres = mac_valid_i && mac_ready_o;
      hs_res  = res_valid_o && res_ready_i;
      if (hs_mreq) begin
         pend_res = mac_c_o + 32'(dot(mac_row_o, mac_col_o));
         c_seen.push_back(mac_c_o);
      end
      if (hs_job) begin
         exp_cycles = 1;
         exp_stall  = 0;
      end else if (phase == 1) begin
         exp_cycles++;
      end
      if ((phase == 1) && mac_valid_o && !mac_ready_i) exp_stall++;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      job_valid_i = 1'b0; op_valid_i = 1'b0; mac_ready_i = 1'b0;
      mac_valid_i = 1'b0; res_ready_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      hs_job = 1'b0; hs_op = 1'b0; hs_mreq = 1'b0; hs_mres = 1'b0; hs_res = 1'b0;
      phase = 2;
      mac_pend = 1'b0;
      check("rst_job_ready", {31'd0, job_ready_o}, 32'd1);
      check("rst_valids", {28'd0, op_ready_o, mac_valid_o, mac_ready_o, res_valid_o}, 32'd0);
      check("rst_acc", res_data_o, 32'd0);
      check("rst_c", mac_c_o, 32'd0);
      check("rst_operands", mac_row_o | mac_col_o, 32'd0);
      check("rst_bs", {22'd0, mac_bs_a_o, mac_bs_b_o}, 32'd0);
      check("rst_err", {31'd0, res_err_o}, 32'd0);
`ifdef SEQ_MAC_DRIVER_PERF_EN
      check("rst_perf", perf_cycles_o | perf_stall_o, 32'd0);
`endif
   endtask

   task automatic run_job(input int len, input logic [31:0] bias, input int bsa, input int bsb,
                          input int stall, input int hold, input bit r, input bit abort);
      int n;
      jb_len   = len;
      jb_bias  = bias;
      jb_bsa   = 5'(bsa);
      jb_bsb   = 5'(bsb);
      jb_legal = (bsa >= 1) && (bsa <= 8) && (bsb >= 1) && (bsb <= 8);
      exp_c[0] = bias;
      for (int i = 0; i < len; i++) exp_c[i + 1] = exp_c[i] + 32'(dot(rows[i], cols[i]));
      exp_res  = jb_legal ? exp_c[len] : bias;
      exp_err  = !jb_legal;
      phase = 0; beat_idx = 0; issue_idx = 0; since = 0;
      op_lat = -1; res_lat = -1;
      stall_left = stall; hold_left = hold; rnd = r;
      got_res = 32'hXXXXXXXX;
      c_seen.delete();
      n = 0;
      while ((phase != 2) && !(abort && mac_pend) && (n < 3000)) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL job_timeout: phase %0d after %0d cycles, required completion", phase, n);
         do_reset();
      end
`ifdef SEQ_MAC_DRIVER_PERF_EN
      if (!abort) begin
         check("perf_cycles", perf_cycles_o, 32'(exp_cycles));
         check("perf_stall", perf_stall_o, 32'(exp_stall));
      end
`endif
   endtask

   task automatic set_job2();
      rows[0] = {16'h0000, 16'h0002}; cols[0] = {16'h0000, 16'h0002};
      rows[1] = {16'h0000, 16'hFFFD}; cols[1] = {16'h0000, 16'h0003};
      rows[2] = {16'h0000, 16'h000A}; cols[2] = {16'h0000, 16'h000A};
   endtask

   task automatic fill_random(input int len);
      logic [31:0] t;
      for (int i = 0; i < len; i++) begin
         t = $urandom; rows[i] = t;
         t = $urandom; cols[i] = t;
      end
   endtask

   initial begin
      job_len_i = 8'd0; job_bias_i = 32'd0; job_bs_a_i = 5'd0; job_bs_b_i = 5'd0;
      op_row_i = '0; op_col_i = '0; mac_d_i = 32'd0;
      do_reset();

      rows[0] = {16'hFFFE, 16'h0003};
      cols[0] = {16'h0007, 16'h0005};
      run_job(1, 32'd10, 4, 4, 0, 0, 1'b0, 1'b0);
      check("t1_res", got_res, 32'd11);
      check("t1_err", {31'd0, got_err}, 32'd0);
      check("t1_c_n", c_seen.size(), 32'd1);
      if (c_seen.size() > 0) check("t1_c0", c_seen[0], 32'd10);
      check("t1_op_lat", op_lat, 32'd1);
      check("t1_res_lat", res_lat, 32'd4);

      set_job2();
      run_job(3, 32'd0, 4, 4, 0, 0, 1'b0, 1'b0);
      check("t2_res", got_res, 32'd95);
      check("t2_c_n", c_seen.size(), 32'd3);
      if (c_seen.size() == 3) begin
         check("t2_c0", c_seen[0], 32'd0);
         check("t2_c1", c_seen[1], 32'd4);
         check("t2_c2", c_seen[2], 32'hFFFFFFFB);
      end

      set_job2();
      run_job(3, 32'd0, 4, 4, 5, 3, 1'b0, 1'b0);
      check("t3_res", got_res, 32'd95);
`ifdef SEQ_MAC_DRIVER_PERF_EN
      check("t3_perf_stall", perf_stall_o, 32'd5);
`endif

      run_job(0, 32'h7FFFFFFF, 4, 4, 0, 0, 1'b0, 1'b0);
      check("t4_res", got_res, 32'h7FFFFFFF);
      check("t4_res_lat", res_lat, 32'd1);
      check("t4_no_op_ready", op_lat, 32'hFFFFFFFF);

      fill_random(2);
      run_job(2, 32'hFFFFFFFF, 0, 4, 0, 0, 1'b0, 1'b0);
      check("t5_res", got_res, 32'hFFFFFFFF);
      check("t5_err", {31'd0, got_err}, 32'd1);
      check("t5_no_mac", c_seen.size(), 32'd0);

      set_job2();
      run_job(3, 32'd0, 4, 4, 0, 0, 1'b0, 1'b0);
      check("t5_next_res", got_res, 32'd95);
      check("t5_next_err", {31'd0, got_err}, 32'd0);

      set_job2();
      run_job(3, 32'd0, 4, 4, 0, 0, 1'b0, 1'b1);
      do_reset();
      set_job2();
      run_job(3, 32'd0, 4, 4, 0, 0, 1'b0, 1'b0);
      check("t6_res", got_res, 32'd95);

      for (int j = 0; j < 40; j++) begin
         int len;
         len = $urandom_range(0, 6);
         fill_random(len);
         run_job(len, $urandom, $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/seq_mac_driver.md
Name: seq_mac_driver

Overview:
- Initiator that feeds the bit-serial K-wide multiply-accumulate unit and consumes its results.
- Accepts a dot-product job (length in K-element beats, 32-bit bias, operand digit widths) and pulls operand beats from a stream.
- Issues one MAC operation per beat, chaining each result back as the next C input, and returns the final 32-bit sum on a result handshake.
- Sits between the operand buffers/controller and the MAC array.

Parameters:
K, 2, elements per operand beat (matches MAC K)
MAX_WIDTH, 16, max operand width in bits
P, 2, digit width in bits; bit sizes are counted in P-bit digits
LEN_W, 8, width of the job length field
BS_W, $clog2(MAX_WIDTH/P)+2, width of the bit-size fields (derived; not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  job descriptor accepted
job_len_i  in  LEN_W  number of operand beats
job_bias_i  in  32  initial accumulator value
job_bs_a_i  in  BS_W  row operand size in digits
job_bs_b_i  in  BS_W  column operand size in digits
op_valid_i  in  1  operand beat valid
op_ready_o  out  1  operand beat accepted
op_row_i  in  K x MAX_WIDTH signed  row elements
op_col_i  in  K x MAX_WIDTH signed  column elements
mac_valid_o  out  1  MAC request valid
mac_ready_i  in  1  MAC ready for request
mac_row_o  out  K x MAX_WIDTH  registered row beat
mac_col_o  out  K x MAX_WIDTH  registered column beat
mac_c_o  out  32  accumulator passed as C
mac_bs_a_o  out  BS_W  latched job_bs_a_i
mac_bs_b_o  out  BS_W  latched job_bs_b_i
mac_valid_i  in  1  MAC result valid
mac_ready_o  out  1  MAC result accepted
mac_d_i  in  32  MAC result
res_valid_o  out  1  job result valid
res_ready_i  in  1  job result accepted
res_data_o  out  32  final accumulator
res_err_o  out  1  job had an illegal bit size

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0 except job_ready_o=1. acc, operand registers, bit sizes and counter are 0. Reset takes effect on any cycle, including mid-job. The in-flight MAC shares this reset; the integration level inverts it for the MAC.
- Handshakes: a transfer occurs when valid&&ready on a rising edge. The driver never drops a valid before the matching ready. mac_row_o, mac_col_o, mac_c_o and mac_bs_* stay stable from issue until the result is accepted.
- FSM:
  - IDLE: job_ready_o=1. On job handshake, latch acc<=bias, rem<=len and the bit sizes.
    - legal = bs in 1..MAX_WIDTH/P for both operands.
    - len==0 -> DONE (err = !legal).
    - !legal -> DRAIN.
    - otherwise -> FETCH.
  - FETCH: op_ready_o=1. On beat handshake, register row/col -> ISSUE.
  - ISSUE: mac_valid_o=1. On mac_ready_i -> WAIT.
  - WAIT: mac_ready_o=1. On mac_valid_i: acc<=mac_d_i, rem<=rem-1. Then rem==1 -> DONE, else FETCH.
  - DRAIN: op_ready_o=1. Each beat is dropped and rem decrements; the last beat -> DONE with err=1. This keeps the operand stream aligned.
  - DONE: res_valid_o=1, res_data_o=acc, res_err_o=err. On res_ready_i -> IDLE.
- Latency, no stalls: job accept to first op_ready_o is 1 cycle. Each beat costs 2 cycles plus MAC compute time. The final MAC result to res_valid_o is 1 cycle.
- Arithmetic: acc is 32-bit two's complement. Wrap-around is modular with no saturation. The driver adds nothing itself; all summation is done by the MAC via C.
- Only one job is in flight. job_ready_o is 0 outside IDLE.
- A mac_valid_i arriving outside WAIT is ignored (mac_ready_o=0).

Optional Feature:
SEQ_MAC_DRIVER_PERF_EN defined adds two ports:
- perf_cycles_o (32): cycles from job handshake through result handshake, inclusive.
- perf_stall_o (32): cycles in ISSUE with mac_ready_i=0.

Both counters clear on each job accept, hold after DONE and reset to 0. With the macro undefined, the ports and counters are absent.

Test Plan:
- K=2, P=2, bs_a=bs_b=4, len=1, bias=10, row{3,-2}, col{5,7}, ideal MAC -> mac_c_o=10, res_data_o=11, res_err_o=0.
- len=3, bias=0, beats give partial dot products 4, -9, 100 -> mac_c_o sequence 0, 4, -5; res_data_o=95.
- Same job with mac_ready_i held low 5 cycles and res_ready_i low 3 cycles -> mac_* outputs stable throughout, res held, same result; with PERF_EN, perf_stall_o=5.
- len=0, bias=0x7FFFFFFF -> no op_ready_o and no mac_valid_o; res_data_o=0x7FFFFFFF one cycle after accept.
- bs_a=0, len=2, bias=-1 -> exactly 2 beats consumed, mac_valid_o never set, res_data_o=0xFFFFFFFF, res_err_o=1; the next legal job computes correctly.
- rst_i pulsed during WAIT -> next cycle IDLE, job_ready_o=1, all other valids 0; a fresh job completes normally.
